// File: rtl/aig_tt_sweeper.sv
// aig_tt_sweeper: walks every input vector of an NVARS-input AIG function in
// ascending order, holds each vector for SETTLE+1 cycles, samples the AIG
// output into a truth table and scores it against an expected table.
// Optional feature macro: AIG_TT_FIRST_FAIL_EN adds ff_vld_o / ff_idx_o,
// reporting the index of the first mismatching sample of a sweep.
module aig_tt_sweeper #(
    parameter int NVARS  = 4,
    parameter int SETTLE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [(1<<NVARS)-1:0]   exp_tt_i,
    output logic [NVARS-1:0]        x_o,
    input  logic                    y_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [(1<<NVARS)-1:0]   tt_o,
    output logic                    pass_o,
    output logic [NVARS:0]          mism_cnt_o
`ifdef AIG_TT_FIRST_FAIL_EN
    ,
    output logic                    ff_vld_o,
    output logic [NVARS-1:0]        ff_idx_o
`endif
);

    localparam int TT_W = 1 << NVARS;
    localparam logic [3:0]       SETTLE_W = 4'(SETTLE);
    localparam logic [NVARS-1:0] IDX_LAST = {NVARS{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [NVARS-1:0]  idx_q, idx_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [TT_W-1:0]   exp_q, exp_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [NVARS:0]    mism_q, mism_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              ff_vld_q, ff_vld_d;
    logic [NVARS-1:0]  ff_idx_q, ff_idx_d;

    logic accept;
    logic sample;
    logic last;
    logic miss;

    assign accept = start_i && !abort_i;
    assign sample = (wcnt_q == SETTLE_W);
    assign last   = (idx_q == IDX_LAST);
    assign miss   = y_i ^ exp_q[idx_q];

    // State register: IDLE on reset, otherwise follow the next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start launches a sweep, abort or the final sample ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (sample && last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: vector stepping, settle wait, sampling and scoring.
    always_comb begin
        idx_d    = idx_q;
        wcnt_d   = wcnt_q;
        exp_d    = exp_q;
        tt_d     = tt_q;
        mism_d   = mism_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        ff_vld_d = ff_vld_q;
        ff_idx_d = ff_idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    exp_d    = exp_tt_i;
                    idx_d    = '0;
                    wcnt_d   = '0;
                    tt_d     = '0;
                    mism_d   = '0;
                    pass_d   = 1'b0;
                    ff_vld_d = 1'b0;
                    ff_idx_d = '0;
                end
            end
            RUN: begin
                if (abort_i) begin
                    idx_d  = '0;
                    wcnt_d = '0;
                    pass_d = 1'b0;
                end else if (!sample) begin
                    wcnt_d = wcnt_q + 4'd1;
                end else begin
                    tt_d[idx_q] = y_i;
                    mism_d      = mism_q + (NVARS+1)'(miss);
                    if (miss && !ff_vld_q) begin
                        ff_vld_d = 1'b1;
                        ff_idx_d = idx_q;
                    end
                    wcnt_d = '0;
                    if (!last) begin
                        idx_d = idx_q + NVARS'(1);
                    end else begin
                        idx_d  = '0;
                        done_d = 1'b1;
                        pass_d = (mism_d == '0);
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers: everything returns to zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            wcnt_q   <= '0;
            exp_q    <= '0;
            tt_q     <= '0;
            mism_q   <= '0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
            ff_vld_q <= 1'b0;
            ff_idx_q <= '0;
        end else begin
            idx_q    <= idx_d;
            wcnt_q   <= wcnt_d;
            exp_q    <= exp_d;
            tt_q     <= tt_d;
            mism_q   <= mism_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
            ff_vld_q <= ff_vld_d;
            ff_idx_q <= ff_idx_d;
        end
    end

    assign x_o        = idx_q;
    assign busy_o     = (state_q == RUN);
    assign done_o     = done_q;
    assign tt_o       = tt_q;
    assign pass_o     = pass_q;
    assign mism_cnt_o = mism_q;

`ifdef AIG_TT_FIRST_FAIL_EN
    assign ff_vld_o = ff_vld_q;
    assign ff_idx_o = ff_idx_q;
`else
    logic unusedFf;
    assign unusedFf = ff_vld_q ^ (^ff_idx_q);
`endif

endmodule

// File: tb/tb_aig_tt_sweeper.sv
// Testbench for aig_tt_sweeper: two instances (SETTLE=0 and SETTLE=2) driven by
// a modelled AIG whose output is a lookup into a bench-held truth table.
// Expected x sequence, latency, truth table and score come from that table.
module tb_aig_tt_sweeper;

   localparam int SETTLE0 = 0;
   localparam int SETTLE1 = 2;

   logic clk;
   logic rst_n;
   logic startI[2];
   logic abortI[2];
   logic [15:0] expTtI[2];
   logic [3:0] xO[2];
   logic yI[2];
   logic busyO[2];
   logic doneO[2];
   logic [15:0] ttO[2];
   logic passO[2];
   logic [4:0] mismO[2];
`ifdef AIG_TT_FIRST_FAIL_EN
   logic ffVldO[2];
   logic [3:0] ffIdxO[2];
`endif

   logic [15:0] aigTt;
   int testsRun;
   int failed;

   typedef struct {
      int dutSel;
      logic [15:0] aig;
      logic [15:0] expTt;
      bit expPass;
      int expMism;
   } vec_t;

   vec_t vecs[7];

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // The AIG under test is modelled as a pure lookup on its input vector.
   assign yI[0] = aigTt[xO[0]];
   assign yI[1] = aigTt[xO[1]];

   aig_tt_sweeper #(.NVARS(4), .SETTLE(SETTLE0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start_i(startI[0]), .abort_i(abortI[0]),
      .exp_tt_i(expTtI[0]), .x_o(xO[0]), .y_i(yI[0]), .busy_o(busyO[0]),
      .done_o(doneO[0]), .tt_o(ttO[0]), .pass_o(passO[0]), .mism_cnt_o(mismO[0])
`ifdef AIG_TT_FIRST_FAIL_EN
      , .ff_vld_o(ffVldO[0]), .ff_idx_o(ffIdxO[0])
`endif
   );

   aig_tt_sweeper #(.NVARS(4), .SETTLE(SETTLE1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start_i(startI[1]), .abort_i(abortI[1]),
      .exp_tt_i(expTtI[1]), .x_o(xO[1]), .y_i(yI[1]), .busy_o(busyO[1]),
      .done_o(doneO[1]), .tt_o(ttO[1]), .pass_o(passO[1]), .mism_cnt_o(mismO[1])
`ifdef AIG_TT_FIRST_FAIL_EN
      , .ff_vld_o(ffVldO[1]), .ff_idx_o(ffIdxO[1])
`endif
   );

   // Single comparison point: counts every check, reports each failure.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Every output of both instances must read zero while/after reset.
   task automatic checkReset(input string name);
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("%s x%0d", name, d), 32'(xO[d]), 0);
         checkOutput($sformatf("%s busy%0d", name, d), 32'(busyO[d]), 0);
         checkOutput($sformatf("%s done%0d", name, d), 32'(doneO[d]), 0);
         checkOutput($sformatf("%s tt%0d", name, d), 32'(ttO[d]), 0);
         checkOutput($sformatf("%s pass%0d", name, d), 32'(passO[d]), 0);
         checkOutput($sformatf("%s mism%0d", name, d), 32'(mismO[d]), 0);
`ifdef AIG_TT_FIRST_FAIL_EN
         checkOutput($sformatf("%s ffvld%0d", name, d), 32'(ffVldO[d]), 0);
         checkOutput($sformatf("%s ffidx%0d", name, d), 32'(ffIdxO[d]), 0);
`endif
      end
   endtask

   // Load the AIG function and expected table, pulse start across one edge (E0).
   task automatic applyStimulus(input int d, input logic [15:0] aig, input logic [15:0] expTt);
      aigTt = aig;
      expTtI[d] = expTt;
      startI[d] = 1'b1;
      @(posedge clk);
      #1;
      startI[d] = 1'b0;
   endtask

   // Follow a sweep from E0+1 time unit to the done pulse and score it.
   // Optionally pulses start mid-run, or restarts in the done cycle.
   task automatic trackSweep(input int d, input logic [15:0] aig, input logic [15:0] expTt,
                             input bit expPass, input int expMism, input int startPulseAt,
                             input bit chain, input logic [15:0] chainExp, input string name);
      int settle;
      int len;
      int firstFail;
      settle = (d == 0) ? SETTLE0 : SETTLE1;
      len = 16 * (settle + 1);
      firstFail = -1;
      for (int i = 15; i >= 0; i--) begin
         if (aig[i] != expTt[i]) firstFail = i;
      end
      for (int k = 0; k < len; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         if (k == 1) expTtI[d] = 16'($urandom);
         startI[d] = (k == startPulseAt);
         checkOutput($sformatf("%s x k=%0d", name, k), 32'(xO[d]), 32'(k / (settle + 1)));
         checkOutput($sformatf("%s busy k=%0d", name, k), 32'(busyO[d]), 1);
         checkOutput($sformatf("%s done k=%0d", name, k), 32'(doneO[d]), 0);
      end
      startI[d] = 1'b0;
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s done", name), 32'(doneO[d]), 1);
      checkOutput($sformatf("%s busy at done", name), 32'(busyO[d]), 0);
      checkOutput($sformatf("%s x at done", name), 32'(xO[d]), 0);
      checkOutput($sformatf("%s tt", name), 32'(ttO[d]), 32'(aig));
      checkOutput($sformatf("%s pass", name), 32'(passO[d]), 32'(expPass));
      checkOutput($sformatf("%s mism", name), 32'(mismO[d]), 32'(expMism));
`ifdef AIG_TT_FIRST_FAIL_EN
      checkOutput($sformatf("%s ffvld", name), 32'(ffVldO[d]), 32'(firstFail >= 0));
      checkOutput($sformatf("%s ffidx", name), 32'(ffIdxO[d]), (firstFail >= 0) ? 32'(firstFail) : 0);
`endif
      if (chain) begin
         expTtI[d] = chainExp;
         startI[d] = 1'b1;
         @(posedge clk);
         #1;
         startI[d] = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("%s done pulse", name), 32'(doneO[d]), 0);
         checkOutput($sformatf("%s pass hold", name), 32'(passO[d]), 32'(expPass));
         checkOutput($sformatf("%s mism hold", name), 32'(mismO[d]), 32'(expMism));
         checkOutput($sformatf("%s tt hold", name), 32'(ttO[d]), 32'(aig));
      end
   endtask

   // Main sequence: reset, table vectors, corner sequences, random sweeps.
   initial begin
      testsRun = 0;
      failed = 0;
      rst_n = 1'b0;
      aigTt = '0;
      for (int d = 0; d < 2; d++) begin
         startI[d] = 1'b0;
         abortI[d] = 1'b0;
         expTtI[d] = '0;
      end
      #2;
      checkReset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      vecs[0] = '{0, 16'h8888, 16'h8888, 1'b1, 0};
      vecs[1] = '{1, 16'h6996, 16'h6996, 1'b1, 0};
      vecs[2] = '{0, 16'h8888, 16'h8880, 1'b0, 1};
      vecs[3] = '{0, 16'h0000, 16'hFFFF, 1'b0, 16};
      vecs[4] = '{1, 16'h8888, 16'h8880, 1'b0, 1};
      vecs[5] = '{0, 16'hFFFF, 16'h0000, 1'b0, 16};
      vecs[6] = '{1, 16'h0000, 16'hFFFF, 1'b0, 16};

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].dutSel, vecs[i].aig, vecs[i].expTt);
         trackSweep(vecs[i].dutSel, vecs[i].aig, vecs[i].expTt, vecs[i].expPass,
                    vecs[i].expMism, -1, 1'b0, 16'h0, $sformatf("vec%0d", i));
      end

      // start together with abort in IDLE must not launch a sweep
      startI[0] = 1'b1;
      abortI[0] = 1'b1;
      @(posedge clk);
      #1;
      startI[0] = 1'b0;
      abortI[0] = 1'b0;
      checkOutput("idle start+abort busy", 32'(busyO[0]), 0);
      checkOutput("idle start+abort tt", 32'(ttO[0]), 32'h0000FFFF);

      // abort at x==5: partial results retained, no done pulse
      applyStimulus(0, 16'h8888, 16'h8880);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      checkOutput("abort pre x", 32'(xO[0]), 5);
      abortI[0] = 1'b1;
      @(posedge clk);
      #1;
      abortI[0] = 1'b0;
      checkOutput("abort busy", 32'(busyO[0]), 0);
      checkOutput("abort x", 32'(xO[0]), 0);
      checkOutput("abort done", 32'(doneO[0]), 0);
      checkOutput("abort pass", 32'(passO[0]), 0);
      checkOutput("abort tt", 32'(ttO[0]), 32'h0008);
      checkOutput("abort mism", 32'(mismO[0]), 1);
`ifdef AIG_TT_FIRST_FAIL_EN
      checkOutput("abort ffvld", 32'(ffVldO[0]), 1);
      checkOutput("abort ffidx", 32'(ffIdxO[0]), 3);
`endif
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("abort no done %0d", k), 32'(doneO[0]), 0);
      end
      applyStimulus(0, 16'h8888, 16'h8888);
      trackSweep(0, 16'h8888, 16'h8888, 1'b1, 0, -1, 1'b0, 16'h0, "after abort");

      // reset mid-sweep at x==9
      applyStimulus(0, 16'h8888, 16'h8880);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      checkOutput("rst pre x", 32'(xO[0]), 9);
      #1;
      rst_n = 1'b0;
      #1;
      checkReset("mid reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post rst busy", 32'(busyO[0]), 0);
      checkOutput("post rst done", 32'(doneO[0]), 0);

      // start pulse mid-run ignored, then back-to-back sweep from the done cycle
      applyStimulus(0, 16'h8888, 16'h8888);
      trackSweep(0, 16'h8888, 16'h8888, 1'b1, 0, 3, 1'b1, 16'h8880, "b2b first");
      trackSweep(0, 16'h8888, 16'h8880, 1'b0, 1, -1, 1'b0, 16'h0, "b2b second");
      applyStimulus(1, 16'h6996, 16'h6996);
      trackSweep(1, 16'h6996, 16'h6996, 1'b1, 0, 7, 1'b1, 16'h6997, "b2b s2 first");
      trackSweep(1, 16'h6996, 16'h6997, 1'b0, 1, -1, 1'b0, 16'h0, "b2b s2 second");

      // random functions and expectations scored by population count
      for (int r = 0; r < 8; r++) begin
         logic [15:0] aig;
         logic [15:0] expT;
         int mism;
         aig = 16'($urandom);
         expT = (r % 3 == 0) ? aig : 16'($urandom);
         if (r % 3 == 1) expT = aig ^ (16'h1 << $urandom_range(15, 0));
         mism = $countones(aig ^ expT);
         applyStimulus(r % 2, aig, expT);
         trackSweep(r % 2, aig, expT, mism == 0, mism, -1, 1'b0, 16'h0, $sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failed);
      $finish;
   end

endmodule
